// File: rtl/datapath_pkg.sv
// Shared datapath types and constants for the 64-bit ARM single-cycle core.
package datapath_pkg;
  localparam int DATA_WIDTH     = 64;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]     dword_t;

  localparam reg_idx_t XZR_IDX = 5'd31;
endpackage

// File: rtl/register_file.sv
// Architectural register file: X0-X30 in flops, XZR (top index) reads zero.
// Two combinational read ports, one clocked write port, optional forwarding.
module register_file #(
  parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = datapath_pkg::REG_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  // Top index is the zero register; it has no storage behind it.
  localparam int                  NUM_REGS = (1 << ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] XZR    = {ADDR_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en_d;

  // A write to XZR is dropped here so it can neither store nor forward.
  assign wr_en_d = reg_write && (write_reg != XZR);

  // Storage: async clear, one write per rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en_d) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Read mux shared by both ports. Forwarding is suppressed during reset
  // so the outputs stay at zero while reset is held.
  function automatic logic [DATA_WIDTH-1:0] rd_mux(input logic [ADDR_WIDTH-1:0] idx);
    if (idx == XZR)                                   return '0;
    if (BYPASS && wr_en_d && !reset && write_reg == idx) return write_data;
    return regs_q[idx];
  endfunction

  // Combinational read ports.
  always_comb begin
    read_data1 = rd_mux(read_reg1);
    read_data2 = rd_mux(read_reg2);
  end

endmodule
